// File: rtl/multi_step_counter_if.sv
// Control/status bundle for multi_step_counter.
// Master drives the requests; slave returns counts and boundary flags.
interface multi_step_counter_if #(
    parameter int NUM_CH      = 4,
    parameter int COUNT_WIDTH = 8
);
    logic [NUM_CH-1:0]             CLEAR;
    logic [NUM_CH*COUNT_WIDTH-1:0] DEFAULT;
    logic [NUM_CH-1:0]             INC;
    logic [NUM_CH-1:0]             DEC;
    logic [NUM_CH*COUNT_WIDTH-1:0] STEP;
    logic [NUM_CH*COUNT_WIDTH-1:0] MIN_COUNT;
    logic [NUM_CH*COUNT_WIDTH-1:0] MAX_COUNT;
    logic [NUM_CH-1:0]             SAT_MODE;
    logic [NUM_CH*COUNT_WIDTH-1:0] COUNT;
    logic [NUM_CH-1:0]             AT_MAX;
    logic [NUM_CH-1:0]             AT_MIN;
    logic [NUM_CH-1:0]             WRAP;

    modport master (
        output CLEAR, DEFAULT, INC, DEC, STEP,
        output MIN_COUNT, MAX_COUNT, SAT_MODE,
        input  COUNT, AT_MAX, AT_MIN, WRAP
    );

    modport slave (
        input  CLEAR, DEFAULT, INC, DEC, STEP,
        input  MIN_COUNT, MAX_COUNT, SAT_MODE,
        output COUNT, AT_MAX, AT_MIN, WRAP
    );
endinterface

// File: rtl/multi_step_counter.sv
// Bank of bounded up/down stride counters with wrap/saturate and WRAP pulse.
// Define COUNTER_CASCADE_EN to ripple up-wrap carries into the next channel.
module multi_step_counter #(
    parameter int NUM_CH      = 4,
    parameter int COUNT_WIDTH = 8
) (
    input logic                 CLK,
    input logic                 RESET,
    multi_step_counter_if.slave bus
);
    localparam int CW = COUNT_WIDTH;
    typedef logic [CW:0] ext_t;

    logic [NUM_CH*CW-1:0] count_q;
    logic [NUM_CH*CW-1:0] count_d;
    logic [NUM_CH-1:0]    wrap_q;
    logic [NUM_CH-1:0]    wrap_d;

    always_comb begin
        ext_t          c;
        ext_t          lo;
        ext_t          hi;
        ext_t          st;
        ext_t          sum;
        ext_t          dif;
        logic          inc;
        logic          up;
        logic          dn;
        logic          ovf;
        logic          unf;
        logic          w;
        logic [CW-1:0] nxt;
`ifdef COUNTER_CASCADE_EN
        logic          carry;
        carry = 1'b0;
`endif
        count_d = count_q;
        wrap_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c   = {1'b0, count_q[i*CW +: CW]};
            lo  = {1'b0, bus.MIN_COUNT[i*CW +: CW]};
            hi  = {1'b0, bus.MAX_COUNT[i*CW +: CW]};
            st  = {1'b0, bus.STEP[i*CW +: CW]};
            sum = c + st;
            dif = c - st;
            inc = bus.INC[i];
`ifdef COUNTER_CASCADE_EN
            inc = bus.INC[i] | carry;
`endif
            up  = inc & ~bus.DEC[i] & (st != '0);
            dn  = ~inc & bus.DEC[i] & (st != '0);
            // Bound tests short-circuit before any difference could go negative
            ovf = (c >= hi) || ((hi - c) < st);
            unf = (c <= lo) || ((c - lo) < st);
            nxt = c[CW-1:0];
            w   = 1'b0;
            if (bus.CLEAR[i]) begin
                nxt = bus.DEFAULT[i*CW +: CW];
            end else if (up) begin
                if (ovf) begin
                    nxt = bus.SAT_MODE[i] ? hi[CW-1:0] : lo[CW-1:0];
                    w   = 1'b1;
                end else begin
                    nxt = sum[CW-1:0];
                end
            end else if (dn) begin
                if (unf) begin
                    nxt = bus.SAT_MODE[i] ? lo[CW-1:0] : hi[CW-1:0];
                    w   = 1'b1;
                end else begin
                    nxt = dif[CW-1:0];
                end
            end
            count_d[i*CW +: CW] = nxt;
            wrap_d[i]           = w;
`ifdef COUNTER_CASCADE_EN
            carry = up & ovf & ~bus.SAT_MODE[i] & ~bus.CLEAR[i];
`endif
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_q <= '0;
            wrap_q  <= '0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        bus.AT_MAX = '0;
        bus.AT_MIN = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.AT_MAX[i] = count_q[i*CW +: CW] == bus.MAX_COUNT[i*CW +: CW];
            bus.AT_MIN[i] = count_q[i*CW +: CW] == bus.MIN_COUNT[i*CW +: CW];
        end
    end

    assign bus.COUNT = count_q;
    assign bus.WRAP  = wrap_q;
endmodule
